// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box, GF(2^8) helpers and controller state type.
// Pure declarations: no latency, no flow control.
package aes_pkg;

  localparam int         NR_AES128 = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_t;

  // Forward S-box; element 0 sits in the MSB so SBOX[b] reads naturally.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // LSB position of state byte (row, col); byte 0 lives in bits 127:120.
  function automatic int byte_lsb(input int row, input int col);
    return 120 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES round plus the matching key-schedule step, purely combinational.
// Zero latency; no flow control.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[byte_lsb(r, c) +: 8] = s[byte_lsb(r, (c + r) % 4) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[byte_lsb(0, c) +: 8];
      a1 = s[byte_lsb(1, c) +: 8];
      a2 = s[byte_lsb(2, c) +: 8];
      a3 = s[byte_lsb(3, c) +: 8];
      o[byte_lsb(0, c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[byte_lsb(1, c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[byte_lsb(2, c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[byte_lsb(3, c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [127:0] sr_state;

  // Each new key word chains off the one just produced.
  always_comb begin
    kw0      = key[127:96] ^ sub_word({key[23:0], key[31:24]}) ^ {rcon, 24'h0};
    kw1      = kw0 ^ key[95:64];
    kw2      = kw1 ^ key[63:32];
    kw3      = kw2 ^ key[31:0];
    next_key = {kw0, kw1, kw2, kw3};

    sr_state   = shift_rows(sub_bytes(state));
    next_state = (last ? sr_state : mix_columns(sr_state)) ^ next_key;
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, ciphertext 10 cycles after accept.
// Holds ciphertext with out_valid until out_ready; no new block accepted until then.
module aes128_iter_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] InputMessage,
  input  logic [127:0] CipherKey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] CodedMessage,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes128_iter_ctrl supports only NR=10");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_state_t   state_q, state_d;
  logic [127:0] blk_q, key_q, out_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic [127:0] rnd_state, rnd_key;
  logic         last_rnd;

  assign last_rnd = (round_q == LAST_RND);

  aes_round_comb u_round (
    .state      (blk_q),
    .key        (key_q),
    .rcon       (rcon_q),
    .last       (last_rnd),
    .next_state (rnd_state),
    .next_key   (rnd_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ROUND;
      ROUND:   if (last_rnd)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // round_q stays at NR through DONE so it never exceeds the round count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q   <= '0;
      key_q   <= '0;
      out_q   <= '0;
      rcon_q  <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            blk_q   <= InputMessage ^ CipherKey;
            key_q   <= CipherKey;
            rcon_q  <= RCON_INIT;
            round_q <= 4'd1;
          end
        end
        ROUND: begin
          blk_q  <= rnd_state;
          key_q  <= rnd_key;
          rcon_q <= xtime(rcon_q);
          if (last_rnd) out_q   <= rnd_state;
          else          round_q <= round_q + 4'd1;
        end
        DONE: begin
          if (out_ready) round_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == DONE);
  assign CodedMessage = out_q;
  assign round_idx    = round_q;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Scoreboard bench for aes128_iter_ctrl: a byte-array AES model with a GF(2^8)-derived
// S-box predicts each accepted block; a negedge monitor checks outputs and timing.
module tb_aes128_iter_ctrl;

  localparam logic [127:0] V1P = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V1K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V1C = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V0C = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] InputMessage = '0;
  logic [127:0] CipherKey = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] CodedMessage;
  logic         busy;
  logic [3:0]   round_idx;

  aes128_iter_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .InputMessage (InputMessage),
    .CipherKey    (CipherKey),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .CodedMessage (CodedMessage),
    .busy         (busy),
    .round_idx    (round_idx)
  );

  always #5 clk = ~clk;

  int           total = 0, bad = 0;
  int           edge_cnt = 0, acc_cnt = 0, out_cnt = 0, acc_edge = 0, acc_prev = 0;
  logic [127:0] sb_q[$];
  logic [127:0] got_log[$];
  logic [7:0]   sbox_t[256];
  logic         prev_ov = 1'b0, prev_stall = 1'b0;
  logic [127:0] prev_dat = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_to(input string nm, input logic ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: condition false, want true", nm);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Textbook AES-128 over byte arrays: s[4c+r] is row r, column c.
  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w[44];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rd + k/4][31-8*(k%4) -: 8];
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  always @(posedge clk) edge_cnt++;

  // Accept tracker + output monitor; handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_aes(InputMessage, CipherKey));
        acc_prev = acc_edge;
        acc_edge = edge_cnt + 1;
        acc_cnt++;
      end
      if (busy && !out_valid) chk("round_idx", {124'h0, round_idx}, 128'(edge_cnt - acc_edge + 1));
      if (!busy) chk("idle_round_idx", {124'h0, round_idx}, 128'h0);
      if (out_valid && !prev_ov) begin
        chk("latency", 128'(edge_cnt - acc_edge), 128'd10);
        chk("done_round_idx", {124'h0, round_idx}, 128'd10);
      end
      if (prev_stall) begin
        chk("hold_valid", {127'h0, out_valid}, 128'd1);
        chk("hold_data", CodedMessage, prev_dat);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got %h want no output", CodedMessage);
        end else begin
          chk("cipher", CodedMessage, sb_q.pop_front());
        end
        got_log.push_back(CodedMessage);
        out_cnt++;
      end
      prev_ov    = out_valid;
      prev_stall = out_valid && !out_ready;
      prev_dat   = CodedMessage;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic [127:0] k);
    int n;
    n = acc_cnt;
    step();
    in_valid = 1'b1; InputMessage = p; CipherKey = k;
    for (int i = 0; i < 60 && acc_cnt == n; i++) step();
    in_valid = 1'b0;
    chk_to("accept_timeout", acc_cnt != n);
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 300 && out_cnt < n; i++) step();
    chk_to("output_timeout", out_cnt >= n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int           o, n;
    logic [127:0] held, p, k, b;
    for (int x = 0; x < 256; x++) begin
      b = '0;
      if (x != 0) begin
        b[7:0] = 8'h01;
        for (int j = 0; j < 254; j++) b[7:0] = gmul(b[7:0], 8'(x));
      end
      sbox_t[x] = b[7:0] ^ rotl8(b[7:0], 1) ^ rotl8(b[7:0], 2) ^ rotl8(b[7:0], 3)
                  ^ rotl8(b[7:0], 4) ^ 8'h63;
    end

    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {127'h0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'h0, out_valid}, 128'd0);
    chk("rst_busy", {127'h0, busy}, 128'd0);
    chk("rst_round_idx", {124'h0, round_idx}, 128'd0);
    chk("rst_coded", CodedMessage, 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    o = out_cnt; send(V1P, V1K); wait_outs(o + 1); chk("kat_v1", got_log[$], V1C);
    o = out_cnt; send(V2P, V2K); wait_outs(o + 1); chk("kat_v2", got_log[$], V2C);

    // Stall the sink for 20 cycles.
    out_ready = 1'b0;
    send(V1P, V1K);
    for (int i = 0; i < 30 && !out_valid; i++) step();
    held = CodedMessage;
    chk("bp_held_kat", held, V1C);
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid", {127'h0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'h0, in_ready}, 128'd0);
      chk("bp_data", CodedMessage, held);
    end
    step();
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {127'h0, out_valid}, 128'd0);
    chk("bp_release_in_ready", {127'h0, in_ready}, 128'd1);

    // in_valid held across two blocks, inputs disturbed mid-round.
    o = out_cnt; n = acc_cnt;
    step();
    in_valid = 1'b1; InputMessage = V1P; CipherKey = V1K;
    for (int i = 0; i < 20 && acc_cnt == n; i++) step();
    repeat (3) step();
    InputMessage = {$urandom, $urandom, $urandom, $urandom};
    CipherKey    = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) step();
    InputMessage = V2P; CipherKey = V2K;
    for (int i = 0; i < 30 && acc_cnt == n + 1; i++) step();
    in_valid = 1'b0;
    chk("b2b_accepts", 128'(acc_cnt - n), 128'd2);
    chk("b2b_interval", 128'(acc_edge - acc_prev), 128'd12);
    wait_outs(o + 2);
    chk("b2b_first", got_log[$-1], V1C);
    chk("b2b_second", got_log[$], V2C);

    // Asynchronous reset in the middle of round 5.
    o = out_cnt;
    send(V2P, V2K);
    for (int i = 0; i < 20 && round_idx != 4'd5; i++) @(negedge clk);
    chk_to("reach_round5", round_idx == 4'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {127'h0, out_valid}, 128'd0);
    chk("arst_busy", {127'h0, busy}, 128'd0);
    chk("arst_in_ready", {127'h0, in_ready}, 128'd1);
    chk("arst_round_idx", {124'h0, round_idx}, 128'd0);
    chk("arst_coded", CodedMessage, 128'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) step();
    chk("arst_no_output", 128'(out_cnt - o), 128'd0);
    chk("arst_idle_valid", {127'h0, out_valid}, 128'd0);
    send(V2P, V2K); wait_outs(o + 1); chk("arst_fresh_kat", got_log[$], V2C);

    o = out_cnt; send('0, '0); wait_outs(o + 1); chk("kat_zero", got_log[$], V0C);

    // Random blocks with a randomly stalling sink.
    for (int v = 0; v < 16; v++) begin
      o = out_cnt;
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) step();
      send(p, k);
      for (int i = 0; i < 300 && out_cnt == o; i++) begin
        step();
        out_ready = 1'($urandom_range(0, 1));
      end
      chk_to("rand_output", out_cnt > o);
      out_ready = 1'b1;
    end

    step();
    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_iter_ctrl.md
Name: aes128_iter_ctrl

Overview:
- Iterative AES-128 encryption controller: one shared round datapath plus on-the-fly key expansion, sequenced one round per clock.
- Replaces the fully unrolled 10-round combinational encryptor wherever area matters more than throughput.
- Sits between a block-source interface and a ciphertext-sink interface, both valid/ready.
- Produces FIPS-197 ciphertext identical to the unrolled encryptor for any key/plaintext.

Parameters:
- NR, 10, number of rounds; only 10 is supported (AES-128); any other value is a synthesis error.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  plaintext and key presented
- in_ready  out  1  controller can accept a block
- InputMessage  in  128  plaintext; byte 0 (state s0,0) = bits 127:120; column-major
- CipherKey  in  128  key, same byte order
- out_valid  out  1  CodedMessage valid
- out_ready  in  1  sink accepts ciphertext
- CodedMessage  out  128  ciphertext, same byte order
- busy  out  1  high while state is not IDLE
- round_idx  out  4  current round number, 0 in IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, busy=0, round_idx=0, CodedMessage=0, state=IDLE. State, key and rcon registers are cleared.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_reg<=InputMessage^CipherKey, key_reg<=CipherKey, rcon<=8'h01, round_idx<=1, go to ROUND.
  - Inputs are sampled only in that handshake cycle; later changes on them are ignored.
- ROUND:
  - in_ready=0.
  - Each cycle: next_key = expand(key_reg, rcon).
    - Word0 = key_w0 ^ SubWord(RotWord(key_w3)) ^ {rcon,24'h0}.
    - Each subsequent word = previous new word ^ corresponding old word.
  - round_idx<NR: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_key.
  - round_idx==NR: MixColumns is omitted.
  - key_reg<=next_key, rcon<=xtime(rcon), round_idx<=round_idx+1.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xtime reduces with 8'h1b.
  - After the round_idx==NR cycle: CodedMessage<=result, out_valid<=1, go to DONE.
- DONE:
  - out_valid=1; CodedMessage held stable until out_ready=1 is sampled.
  - On out_valid&out_ready: out_valid<=0, round_idx<=0.
  - Back to IDLE; in_ready=1 on the next cycle.
  - No combinational in_ready-from-out_ready path. Minimum accept-to-accept interval is 12 cycles.
- Latency: handshake at edge 0 -> out_valid asserted after edge 10 (visible in cycle 11, 10 cycles after acceptance).
- Backpressure: out_ready low indefinitely keeps DONE, out_valid high, data frozen.
- in_valid held high while busy: ignored, no second capture, no corruption.
- Reset asserted mid-ROUND or in DONE: all outputs return to reset values immediately (async). In-flight block discarded; no out_valid after deassertion.
- CodedMessage is a registered output; there is no combinational path from inputs to outputs.
- Widths: round_idx 4-bit, never exceeds NR; rcon 8-bit.

Decomposition:
- Package aes_pkg:
  - S-box constant function/table.
  - xtime function.
  - Rcon initial value 8'h01.
  - NR_AES128=10.
  - FSM state typedef (IDLE/ROUND/DONE).
  - Byte-index helper for column-major state.
- Sub-module aes_round_comb:
  - Purely combinational.
  - Inputs: state, key, rcon, last flag.
  - Outputs: next_state, next_key.
  - Reuses the existing subBytes (inv=0), shiftRowsE, mixColumnsE blocks plus a 4-byte SubWord instance.
- Controller RTL holds only the FSM, registers and handshakes.

Test Plan:
- Vector 1: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid exactly 10 cycles after accept, CodedMessage=3925841d02dc09fbdc118597196a0b32.
- Vector 2: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a; round_idx steps 1..10.
- Backpressure: vector 1 with out_ready=0 for 20 cycles after out_valid -> out_valid stays 1, CodedMessage constant, in_ready=0. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the following cycle.
- Back-to-back with ignored input: in_valid held high continuously with vector 1 then vector 2, inputs changed mid-ROUND -> exactly two outputs, in order, both correct. Accepts spaced 12 cycles apart.
- Async reset: assert rst_n=0 at round_idx=5 between clock edges -> out_valid=0, busy=0, in_ready=1, round_idx=0 immediately. After release, no spurious output; a fresh vector 2 yields correct ciphertext.
- All-zero input: plaintext 0, key 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
